// File: rtl/xc_aesmix_pkg.sv
// Shared definitions for the iterative AES MixColumns / InvMixColumns unit.
package xc_aesmix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Low byte of the AES field polynomial x^8+x^4+x^3+x+1.
    localparam logic [7:0] AES_RED = 8'h1b;

    // Multiply by x in GF(2^8).
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_RED : 8'h00);
    endfunction

endpackage

// File: rtl/xc_aesmix_byte.sv
// One output byte of the forward or inverse column mix, purely combinational.
module xc_aesmix_byte
    import xc_aesmix_pkg::*;
(
    input  logic [7:0] a0_i,   // a_i
    input  logic [7:0] a1_i,   // a_{i+1}
    input  logic [7:0] a2_i,   // a_{i+2}
    input  logic [7:0] a3_i,   // a_{i+3}
    input  logic       inv_i,
    output logic [7:0] b_o
);

    logic [7:0] a0_x2, a0_x4, a0_x8;
    logic [7:0] a1_x2, a1_x4, a1_x8;
    logic [7:0] a2_x2, a2_x4, a2_x8;
    logic [7:0] a3_x2, a3_x4, a3_x8;

    // Chained xtime gives 2x, 4x, 8x of each byte; 9/11/13/14 are XOR sums of these.
    always_comb begin
        a0_x2 = xtime(a0_i);
        a0_x4 = xtime(a0_x2);
        a0_x8 = xtime(a0_x4);
        a1_x2 = xtime(a1_i);
        a1_x4 = xtime(a1_x2);
        a1_x8 = xtime(a1_x4);
        a2_x2 = xtime(a2_i);
        a2_x4 = xtime(a2_x2);
        a2_x8 = xtime(a2_x4);
        a3_x2 = xtime(a3_i);
        a3_x4 = xtime(a3_x2);
        a3_x8 = xtime(a3_x4);
        if (inv_i) begin
            b_o = (a0_x8 ^ a0_x4 ^ a0_x2)          // 14*a_i
                ^ (a1_x8 ^ a1_x2 ^ a1_i)           // 11*a_{i+1}
                ^ (a2_x8 ^ a2_x4 ^ a2_i)           // 13*a_{i+2}
                ^ (a3_x8 ^ a3_i);                  //  9*a_{i+3}
        end else begin
            b_o = a0_x2 ^ (a1_x2 ^ a1_i) ^ a2_i ^ a3_i;
        end
    end

endmodule

// File: rtl/xc_aesmix_seq.sv
// Iterative MixColumns / InvMixColumns on one 32-bit column with valid/ready handshake.
module xc_aesmix_seq
    import xc_aesmix_pkg::*;
#(
    parameter int unsigned FAST = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic        inv,
    input  logic [31:0] col_in,
    output logic        ready,
    output logic [31:0] result
);

    state_e      state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] col_q, col_d;
    logic        inv_q, inv_d;
    logic [31:0] result_q, result_d;

    // Value result takes on a BUSY edge, and whether that edge completes the column.
    logic [31:0] mix_word;
    logic        last;

    if (FAST == 0) begin : g_serial
        logic [31:0] rot;
        logic [7:0]  mix_byte;

        // Rotate the column right so rot[7:0] is a_count.
        always_comb begin
            case (count_q)
                2'd0:    rot = col_q;
                2'd1:    rot = {col_q[7:0], col_q[31:8]};
                2'd2:    rot = {col_q[15:0], col_q[31:16]};
                default: rot = {col_q[23:0], col_q[31:24]};
            endcase
        end

        xc_aesmix_byte u_byte (
            .a0_i  (rot[7:0]),
            .a1_i  (rot[15:8]),
            .a2_i  (rot[23:16]),
            .a3_i  (rot[31:24]),
            .inv_i (inv_q),
            .b_o   (mix_byte)
        );

        // Replace only byte b_count; the rest keep their previous values.
        always_comb begin
            mix_word = result_q;
            mix_word[{count_q, 3'b000} +: 8] = mix_byte;
            last = (count_q == 2'd3);
        end
    end else begin : g_fast
        for (genvar i = 0; i < 4; i++) begin : g_lane
            xc_aesmix_byte u_byte (
                .a0_i  (col_q[8*(i%4) +: 8]),
                .a1_i  (col_q[8*((i+1)%4) +: 8]),
                .a2_i  (col_q[8*((i+2)%4) +: 8]),
                .a3_i  (col_q[8*((i+3)%4) +: 8]),
                .inv_i (inv_q),
                .b_o   (mix_word[8*i +: 8])
            );
        end
        assign last = 1'b1;
    end

    // Next-state: accept in IDLE, compute or abort in BUSY, single-cycle DONE.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        col_d    = col_q;
        inv_d    = inv_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = BUSY;
                    col_d   = col_in;
                    inv_d   = inv;
                    count_d = 2'd0;
                end
            end
            BUSY: begin
                if (!valid) begin
                    state_d = IDLE;
                end else begin
                    result_d = mix_word;
                    count_d  = count_q + 2'd1;
                    if (last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= 2'd0;
            col_q    <= 32'd0;
            inv_q    <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            col_q    <= col_d;
            inv_q    <= inv_d;
            result_q <= result_d;
        end
    end

    assign ready  = (state_q == DONE);
    assign result = result_q;

endmodule
